psum_ctrl: RTL and testbench
============================

PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of row-length config and column counter.
REQ-002 Parameter ROW_W, default 8: width of row/kernel-row config and counters.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse launching a layer.
REQ-006 stall  in  1  global stall; freezes all state.
REQ-007 in_valid  in  1  PE column beat available.
REQ-008 cfg_row_len  in  ADDR_W  beats per output row (buffer depth in use).
REQ-009 cfg_kh  in  ROW_W  kernel rows accumulated per output row.
REQ-010 cfg_rows  in  ROW_W  output rows per layer.
REQ-011 p_init  out  1  zero-fill both partial-sum FIFOs.
REQ-012 p_valid_data  out  1  accumulate PE beat into the active FIFO.
REQ-013 p_write_zero  out  1  drain the idle FIFO and refill it with zero.
REQ-014 odd_cnt  out  1  selects the active FIFO; toggles per output row.
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse at layer end.

Function
REQ-017 FSM states IDLE, INIT, ACCUM, DRAIN, FIN; all outputs are registered.
REQ-018 IDLE: start with stall=0 latches cfg_*, clears counters, enters INIT; start while busy is ignored.
REQ-019 INIT: p_init=1 for exactly cfg_row_len cycles, then ACCUM with col=0, kr=0, row=0, odd_cnt=0.
REQ-020 ACCUM: p_valid_data=in_valid; col advances only on in_valid; col wraps at cfg_row_len-1 and kr increments.
REQ-021 ACCUM: p_write_zero=in_valid while kr=0 and row>0 (drain of previous row overlaps first pass).
REQ-022 At the beat where col=cfg_row_len-1 and kr=cfg_kh-1: kr clears, odd_cnt toggles, row increments; if row=cfg_rows-1, go to DRAIN.
REQ-023 DRAIN: p_write_zero=1, p_valid_data=0 for cfg_row_len cycles, then FIN.
REQ-024 FIN: done=1 one cycle, busy falls, back to IDLE; odd_cnt holds its value until the next start clears it.
REQ-025 stall=1: counters, state and all outputs hold their value; no beat is counted; in_valid is ignored.
REQ-026 Any of cfg_row_len, cfg_kh, cfg_rows equal to 0 at start: go straight to FIN, no strobe asserted.
REQ-027 p_init, p_valid_data and p_write_zero are never high together except p_valid_data with p_write_zero.
REQ-028 Counter widths match the cfg widths; no wrap past the cfg values is possible.

Reset
REQ-029 rst asserted: state=IDLE; every output and counter is 0, including mid-operation; no done pulse.
REQ-030 First start after rst deassertion is accepted on the next rising edge.

Configuration
REQ-031 Macro PSUM_CTRL_PERF_EN defined: adds outputs perf_stall_cyc and perf_busy_cyc (32 bit each), cleared on start, counting stall cycles while busy and busy cycles, saturating at all-ones.
REQ-032 Macro undefined: those ports and counters are absent; other behaviour is identical.

Structure
REQ-033 Shared package psum_pkg holds the FSM state encoding and the ADDR_W/ROW_W defaults.
REQ-034 One sub-module psum_beat_cnt: a wrap counter with enable, clear, limit and wrap flag, used for col and kr.

Verification
REQ-035 row_len=4, kh=3, rows=2, in_valid=1, no stall -> p_init 4 cycles; 24 p_valid_data; p_write_zero on beats 13-16 and 4 drain cycles; done at cycle 33 after start.
REQ-036 Same configuration with stall high 5 cycles mid-ACCUM -> identical strobe sequence shifted by 5 cycles; perf_stall_cyc=5 when the macro is set.
REQ-037 in_valid toggling 1,0 -> p_valid_data mirrors in_valid; column advance and odd_cnt toggle only on valid beats.
REQ-038 rst pulse during ACCUM -> all outputs 0 next edge; new start replays the full sequence from INIT.
REQ-039 cfg_kh=0 at start -> done one cycle after FIN entry, zero p_init/p_valid_data/p_write_zero pulses.
REQ-040 start reasserted while busy -> ignored; single done at the original schedule.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum controller: FSM encoding and default widths.
package psum_pkg;
  localparam int PSUM_ADDR_W = 8;
  localparam int PSUM_ROW_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } psum_state_t;
endpackage

// File: rtl/psum_ctrl_if.sv
// Control/strobe bundle between the layer sequencer and the partial-sum controller.
// PSUM_CTRL_PERF_EN adds the two performance counters.
interface psum_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int ROW_W  = 8
);
  logic              start;
  logic              stall;
  logic              in_valid;
  logic [ADDR_W-1:0] cfg_row_len;
  logic [ROW_W-1:0]  cfg_kh;
  logic [ROW_W-1:0]  cfg_rows;
  logic              p_init;
  logic              p_valid_data;
  logic              p_write_zero;
  logic              odd_cnt;
  logic              busy;
  logic              done;
`ifdef PSUM_CTRL_PERF_EN
  logic [31:0]       perf_stall_cyc;
  logic [31:0]       perf_busy_cyc;
`endif

  modport master (
    output start, stall, in_valid, cfg_row_len, cfg_kh, cfg_rows,
`ifdef PSUM_CTRL_PERF_EN
    input  perf_stall_cyc, perf_busy_cyc,
`endif
    input  p_init, p_valid_data, p_write_zero, odd_cnt, busy, done
  );

  modport slave (
    input  start, stall, in_valid, cfg_row_len, cfg_kh, cfg_rows,
`ifdef PSUM_CTRL_PERF_EN
    output perf_stall_cyc, perf_busy_cyc,
`endif
    output p_init, p_valid_data, p_write_zero, odd_cnt, busy, done
  );
endinterface

// File: rtl/psum_beat_cnt.sv
// Wrap counter: counts 0..limit-1 on en, clr has priority; last flags the wrap value.
module psum_beat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);
  assign last = (cnt == limit - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= last ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/psum_ctrl.sv
// Partial-sum double-buffer controller: zero-fill, accumulate kh passes per row, drain.
// Optional PSUM_CTRL_PERF_EN adds stall/busy cycle counters.
module psum_ctrl
  import psum_pkg::*;
#(
  parameter int ADDR_W = PSUM_ADDR_W,
  parameter int ROW_W  = PSUM_ROW_W
) (
  input logic       clk,
  input logic       rst,
  psum_ctrl_if.slave io
);
  psum_state_t       state_q, state_d;
  logic [ADDR_W-1:0] len_q;
  logic [ROW_W-1:0]  kh_q, rows_q, row_q, row_d;
  logic              init_q, pvd_q, pwz_q, odd_q, busy_q, done_q;
  logic              init_d, pvd_d, pwz_d, odd_d, busy_d, done_d;
  logic              col_en, kr_en, cnt_clr, cfg_ld;
  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  kr;
  logic              col_last, kr_last;

  // col also paces the INIT and DRAIN phases; it is back at 0 whenever ACCUM starts.
  psum_beat_cnt #(.W(ADDR_W)) u_col (
    .clk(clk), .rst(rst), .en(col_en & ~io.stall), .clr(cnt_clr & ~io.stall),
    .limit(len_q), .cnt(col), .last(col_last)
  );

  psum_beat_cnt #(.W(ROW_W)) u_kr (
    .clk(clk), .rst(rst), .en(kr_en & ~io.stall), .clr(cnt_clr & ~io.stall),
    .limit(kh_q), .cnt(kr), .last(kr_last)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    odd_d   = odd_q;
    busy_d  = busy_q;
    init_d  = 1'b0;
    pvd_d   = 1'b0;
    pwz_d   = 1'b0;
    done_d  = 1'b0;
    col_en  = 1'b0;
    kr_en   = 1'b0;
    cnt_clr = 1'b0;
    cfg_ld  = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        cfg_ld  = 1'b1;
        cnt_clr = 1'b1;
        busy_d  = 1'b1;
        odd_d   = 1'b0;
        row_d   = '0;
        state_d = (io.cfg_row_len == '0 || io.cfg_kh == '0 || io.cfg_rows == '0) ? FIN : INIT;
      end
      INIT: begin
        init_d = 1'b1;
        col_en = 1'b1;
        if (col_last) state_d = ACCUM;
      end
      ACCUM: if (io.in_valid) begin
        pvd_d  = 1'b1;
        pwz_d  = (kr == '0) && (row_q != '0);
        col_en = 1'b1;
        if (col_last) begin
          kr_en = 1'b1;
          if (kr_last) begin
            odd_d = ~odd_q;
            row_d = row_q + 1'b1;
            if (row_q == rows_q - 1'b1) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        pwz_d  = 1'b1;
        col_en = 1'b1;
        if (col_last) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      kh_q    <= '0;
      rows_q  <= '0;
      row_q   <= '0;
      init_q  <= 1'b0;
      pvd_q   <= 1'b0;
      pwz_q   <= 1'b0;
      odd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!io.stall) begin
      state_q <= state_d;
      row_q   <= row_d;
      init_q  <= init_d;
      pvd_q   <= pvd_d;
      pwz_q   <= pwz_d;
      odd_q   <= odd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (cfg_ld) begin
        len_q  <= io.cfg_row_len;
        kh_q   <= io.cfg_kh;
        rows_q <= io.cfg_rows;
      end
    end
  end

  assign io.p_init       = init_q;
  assign io.p_valid_data = pvd_q;
  assign io.p_write_zero = pwz_q;
  assign io.odd_cnt      = odd_q;
  assign io.busy         = busy_q;
  assign io.done         = done_q;

  a_col_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == ACCUM) |-> (col < len_q));

`ifdef PSUM_CTRL_PERF_EN
  logic [31:0] stall_cyc_q, busy_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      busy_cyc_q  <= '0;
    end else if (cfg_ld && !io.stall) begin
      stall_cyc_q <= '0;
      busy_cyc_q  <= '0;
    end else if (busy_q) begin
      if (~&busy_cyc_q)              busy_cyc_q  <= busy_cyc_q + 1'b1;
      if (io.stall && ~&stall_cyc_q) stall_cyc_q <= stall_cyc_q + 1'b1;
    end
  end

  assign io.perf_stall_cyc = stall_cyc_q;
  assign io.perf_busy_cyc  = busy_cyc_q;
`endif
endmodule

// File: tb/tb_psum_ctrl.sv
// Directed bench for psum_ctrl: strobe timelines recorded as per-cycle masks vs hand-computed ranges.
module tb_psum_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_ctrl_if #(.ADDR_W(8), .ROW_W(8)) io();
  psum_ctrl #(.ADDR_W(8), .ROW_W(8)) dut (.clk(clk), .rst(rst), .io(io));

  int checks = 0;
  int failures = 0;

  logic [63:0] m_init, m_pvd, m_pwz, m_odd, m_busy;
  int done_j, done_k, n_done, ovl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int a, input int b);
    logic [63:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] outs();
    return {58'd0, io.p_init, io.p_valid_data, io.p_write_zero, io.odd_cnt, io.busy, io.done};
  endfunction

  // Cycle k = interval after the k-th edge following the start edge; stalled edges are
  // dropped from the mask index j so a stalled run compresses back to the unstalled one.
  task automatic run_layer(input logic [7:0] len, input logic [7:0] kh, input logic [7:0] rows,
                           input int st_at, input int st_len, input bit tog, input int re_at);
    int k, j;
    bit st_e;
    m_init = '0; m_pvd = '0; m_pwz = '0; m_odd = '0; m_busy = '0;
    done_j = -1; done_k = -1; n_done = 0; ovl = 0;
    io.cfg_row_len = len; io.cfg_kh = kh; io.cfg_rows = rows;
    io.start = 1'b1; io.stall = 1'b0; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    k = 0; j = 0; st_e = 1'b0;
    while (k < 200 && !(n_done > 0 && k >= done_k + 3)) begin
      if (!st_e && j < 64) begin
        m_init[j] = io.p_init;
        m_pvd[j]  = io.p_valid_data;
        m_pwz[j]  = io.p_write_zero;
        m_odd[j]  = io.odd_cnt;
        m_busy[j] = io.busy;
        if (io.done) done_j = j;
        j++;
      end
      if (io.done) begin n_done++; done_k = k; end
      if (io.p_init && (io.p_valid_data || io.p_write_zero)) ovl++;
      st_e = (k + 1 >= st_at) && (k + 1 < st_at + st_len);
      io.stall    = st_e;
      io.in_valid = tog ? ((k + 1) % 2 == 1) : 1'b1;
      io.start    = (k + 1 == re_at);
      @(posedge clk); #1;
      k++;
    end
    io.stall = 1'b0; io.in_valid = 1'b0; io.start = 1'b0;
  endtask

  task automatic chk_base(input string t);
    chk({t, "_init"}, m_init, rng(1, 4));
    chk({t, "_pvd"},  m_pvd,  rng(5, 28));
    chk({t, "_pwz"},  m_pwz,  rng(17, 20) | rng(29, 32));
    chk({t, "_odd"},  m_odd,  rng(16, 27));
    chk({t, "_busy"}, m_busy, rng(0, 32));
    chk({t, "_donej"}, done_j, 33);
    chk({t, "_ndone"}, n_done, 1);
    chk({t, "_ovl"},  ovl, 0);
  endtask

  initial begin
    logic [63:0] exp_pvd;
    io.start = 1'b0; io.stall = 1'b0; io.in_valid = 1'b0;
    io.cfg_row_len = '0; io.cfg_kh = '0; io.cfg_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", outs(), 64'd0);
    rst = 1'b0;

    // Nominal layer: 4 beats/row, 3 kernel rows, 2 output rows.
    run_layer(8'd4, 8'd3, 8'd2, -1, 0, 1'b0, -1);
    chk_base("base");
    chk("base_donek", done_k, 33);
`ifdef PSUM_CTRL_PERF_EN
    chk("base_perf_busy", io.perf_busy_cyc, 33);
    chk("base_perf_stall", io.perf_stall_cyc, 0);
`endif

    // Five stall edges mid-ACCUM: same sequence, shifted by 5.
    run_layer(8'd4, 8'd3, 8'd2, 10, 5, 1'b0, -1);
    chk_base("stall");
    chk("stall_donek", done_k, 38);
`ifdef PSUM_CTRL_PERF_EN
    chk("stall_perf_stall", io.perf_stall_cyc, 5);
    chk("stall_perf_busy", io.perf_busy_cyc, 38);
`endif

    // in_valid high on odd edges only, plus a start pulse while busy.
    run_layer(8'd4, 8'd3, 8'd2, -1, 0, 1'b1, 11);
    exp_pvd = '0;
    for (int e = 5; e <= 51; e += 2) exp_pvd[e] = 1'b1;
    chk("tog_init", m_init, rng(1, 4));
    chk("tog_pvd", m_pvd, exp_pvd);
    chk("tog_pwz", m_pwz, rng(29, 29) | rng(31, 31) | rng(33, 33) | rng(35, 35) | rng(52, 55));
    chk("tog_odd", m_odd, rng(27, 50));
    chk("tog_donek", done_k, 56);
    chk("tog_ndone", n_done, 1);

    // Three rows: odd_cnt ends at 1 and holds after done.
    run_layer(8'd2, 8'd1, 8'd3, -1, 0, 1'b0, -1);
    chk("r3_init", m_init, rng(1, 2));
    chk("r3_pvd", m_pvd, rng(3, 8));
    chk("r3_pwz", m_pwz, rng(5, 10));
    chk("r3_odd", m_odd, rng(4, 5) | rng(8, 13));
    chk("r3_donek", done_k, 11);
    chk("r3_odd_hold", io.odd_cnt, 1);

    // Zero kernel rows: straight to FIN, no strobes.
    run_layer(8'd4, 8'd0, 8'd2, -1, 0, 1'b0, -1);
    chk("kh0_strobes", m_init | m_pvd | m_pwz, 64'd0);
    chk("kh0_busy", m_busy, rng(0, 0));
    chk("kh0_donek", done_k, 1);
    chk("kh0_ndone", n_done, 1);

    // Reset in the middle of ACCUM, then a full replay.
    io.cfg_row_len = 8'd4; io.cfg_kh = 8'd3; io.cfg_rows = 8'd2;
    io.start = 1'b1; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_pvd", io.p_valid_data, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_async", outs(), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_edge", outs(), 64'd0);
    rst = 1'b0;
    run_layer(8'd4, 8'd3, 8'd2, -1, 0, 1'b0, -1);
    chk_base("replay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
